// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Run sequencer for the convolution unit. A run walks INIT -> A -> B -> C
//   -> DONE -> INIT. Each layer accepts a latched number of tile beats and
//   then holds for D = MULT_PIPELINE_STAGE + 1 cycles so the multiplier
//   pipeline drains. state_rst from conv control aborts a run synchronously.
//
//   Optional feature: define SEQ_PERF_CNT_EN to build the run_cycles busy
//   counter. When it is undefined, run_cycles is tied to zero.
//
// Ports
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset
//   start          launch a run (sampled only in INIT)
//   tiles_a/b/c    beat count per layer, latched on the accepted start
//   tile_valid     upstream beat available
//   tile_ready     sequencer accepts a beat (forced low while state_rst)
//   state_rst      synchronous abort back to INIT
//   current_state  INIT=000 A=001 B=010 C=011 DONE=100
//   tile_cnt       beats accepted in the current layer
//   layer_first    combinational: accepted beat while tile_cnt == 0
//   busy           high in A, B, C and DONE
//   done           one-cycle pulse in DONE
//   run_cycles     busy-cycle performance counter
module conv_layer_sequencer #(
  parameter int CNT_WIDTH           = 16,
  parameter int MULT_PIPELINE_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] tiles_a,
  input  logic [CNT_WIDTH-1:0] tiles_b,
  input  logic [CNT_WIDTH-1:0] tiles_c,
  input  logic                 tile_valid,
  output logic                 tile_ready,
  input  logic                 state_rst,
  output logic [2:0]           current_state,
  output logic [CNT_WIDTH-1:0] tile_cnt,
  output logic                 layer_first,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          run_cycles
);

  localparam int D  = MULT_PIPELINE_STAGE + 1;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam logic [DW-1:0] DLAST = DW'(D - 1);

  typedef enum logic [2:0] {
    S_INIT = 3'b000,
    S_A    = 3'b001,
    S_B    = 3'b010,
    S_C    = 3'b011,
    S_DONE = 3'b100
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_tiles_a;
  logic [CNT_WIDTH-1:0] r_tiles_b;
  logic [CNT_WIDTH-1:0] r_tiles_c;
  logic [CNT_WIDTH-1:0] r_tile_cnt;
  logic                 r_ready;
  logic                 r_drain;
  logic [DW-1:0]        r_dcnt;
  logic                 r_busy;
  logic                 r_done;

  logic [CNT_WIDTH-1:0] w_limit;
  logic [CNT_WIDTH-1:0] w_next_limit;
  state_t               w_next_layer;
  logic                 w_in_layer;
  logic                 w_accept;
  logic                 w_adv;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  // Current layer's latched count, plus the state/count the layer hands off to.
  always_comb begin
    w_limit      = '0;
    w_next_limit = '0;
    w_next_layer = S_DONE;
    case (r_state)
      S_A: begin
        w_limit      = r_tiles_a;
        w_next_limit = r_tiles_b;
        w_next_layer = S_B;
      end
      S_B: begin
        w_limit      = r_tiles_b;
        w_next_limit = r_tiles_c;
        w_next_layer = S_C;
      end
      S_C: begin
        w_limit      = r_tiles_c;
        w_next_limit = '0;
        w_next_layer = S_DONE;
      end
      default: ;
    endcase
  end

  assign w_in_layer = (r_state == S_A) || (r_state == S_B) || (r_state == S_C);
  // The abort must block a beat in its own cycle, so the registered ready is
  // gated by state_rst here.
  assign tile_ready = r_ready & ~state_rst;
  assign w_accept   = tile_valid & tile_ready;
  assign w_cnt_inc  = r_tile_cnt + CNT_WIDTH'(1);
  // Leave the layer after the last drain cycle, or immediately for a
  // zero-count layer (which never raises ready and never drains).
  assign w_adv      = r_drain ? (r_dcnt == DLAST) : (w_limit == '0);

  assign current_state = r_state;
  assign tile_cnt      = r_tile_cnt;
  assign layer_first   = w_accept & (r_tile_cnt == '0);
  assign busy          = r_busy;
  assign done          = r_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_INIT;
      r_tiles_a  <= '0;
      r_tiles_b  <= '0;
      r_tiles_c  <= '0;
      r_tile_cnt <= '0;
      r_ready    <= 1'b0;
      r_drain    <= 1'b0;
      r_dcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (state_rst) begin
      r_state    <= S_INIT;
      r_tiles_a  <= '0;
      r_tiles_b  <= '0;
      r_tiles_c  <= '0;
      r_tile_cnt <= '0;
      r_ready    <= 1'b0;
      r_drain    <= 1'b0;
      r_dcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (start) begin
            r_tiles_a  <= tiles_a;
            r_tiles_b  <= tiles_b;
            r_tiles_c  <= tiles_c;
            r_tile_cnt <= '0;
            r_state    <= S_A;
            r_busy     <= 1'b1;
            r_ready    <= (tiles_a != '0);
          end
        end
        S_DONE: begin
          r_state <= S_INIT;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
        end
        default: begin
          if (w_in_layer) begin
            if (w_adv) begin
              r_state    <= w_next_layer;
              r_tile_cnt <= '0;
              r_drain    <= 1'b0;
              r_dcnt     <= '0;
              r_ready    <= (w_next_layer != S_DONE) && (w_next_limit != '0);
              r_done     <= (w_next_layer == S_DONE);
            end else if (r_drain) begin
              r_dcnt <= r_dcnt + DW'(1);
            end else if (w_accept) begin
              r_tile_cnt <= w_cnt_inc;
              if (w_cnt_inc == w_limit) begin
                r_drain <= 1'b1;
                r_ready <= 1'b0;
              end
            end
          end else begin
            r_state <= S_INIT;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_run_cycles;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run_cycles <= '0;
    end else if (state_rst) begin
      r_run_cycles <= '0;
    end else if ((r_state == S_INIT) && start) begin
      r_run_cycles <= '0;
    end else if (r_busy) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign run_cycles = r_run_cycles;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (CNT_WIDTH=16, D=3).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_conv_layer_sequencer;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [CW-1:0] tiles_a, tiles_b, tiles_c;
  logic          tile_valid;
  logic          tile_ready;
  logic          state_rst;
  logic [2:0]    current_state;
  logic [CW-1:0] tile_cnt;
  logic          layer_first;
  logic          busy;
  logic          done;
  logic [31:0]   run_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  conv_layer_sequencer #(.CNT_WIDTH(CW), .MULT_PIPELINE_STAGE(2)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .tiles_a       (tiles_a),
    .tiles_b       (tiles_b),
    .tiles_c       (tiles_c),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .state_rst     (state_rst),
    .current_state (current_state),
    .tile_cnt      (tile_cnt),
    .layer_first   (layer_first),
    .busy          (busy),
    .done          (done),
    .run_cycles    (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Basic run 3/2/1 with valid held high: 6 A, 5 B, 4 C, 1 DONE, then INIT.
  logic [2:0] b_st  [17] = '{1,1,1,1,1,1,2,2,2,2,2,3,3,3,3,4,0};
  logic       b_rdy [17] = '{1,1,1,0,0,0,1,1,0,0,0,1,0,0,0,0,0};
  logic       b_lf  [17] = '{1,0,0,0,0,0,1,0,0,0,0,1,0,0,0,0,0};

  // Back-pressure 4/0/0, valid 1,0,1,0... for the first 7 A cycles.
  logic [2:0]    p_st  [14] = '{1,1,1,1,1,1,1,1,1,1,2,3,4,0};
  logic          p_rdy [14] = '{1,1,1,1,1,1,1,0,0,0,0,0,0,0};
  logic [CW-1:0] p_cnt [14] = '{0,1,1,2,2,3,3,4,4,4,0,0,0,0};

  logic [31:0] exp_run;
  int acc;

  initial begin
    rstn = 1'b0; start = 1'b0; state_rst = 1'b0; tile_valid = 1'b0;
    tiles_a = '0; tiles_b = '0; tiles_c = '0;
    #12;
    chk("rst_state", 32'(current_state), 0);
    chk("rst_ready", 32'(tile_ready), 0);
    chk("rst_cnt",   32'(tile_cnt), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_run",   run_cycles, 0);
    rstn = 1'b1;
    step();
    step();
    chk("idle_state", 32'(current_state), 0);

    // ---- basic run ----
    tiles_a = 3; tiles_b = 2; tiles_c = 1; tile_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("basic_st%0d", i),  32'(current_state), 32'(b_st[i]));
      chk($sformatf("basic_rdy%0d", i), 32'(tile_ready),    32'(b_rdy[i]));
      chk($sformatf("basic_lf%0d", i),  32'(layer_first),   32'(b_lf[i]));
      chk($sformatf("basic_done%0d", i), 32'(done), (i == 15) ? 32'd1 : 32'd0);
      step();
    end
`ifdef SEQ_PERF_CNT_EN
    exp_run = 32'd16;  // 6 + 5 + 4 busy layer cycles + 1 DONE cycle
`else
    exp_run = 32'd0;
`endif
    chk("basic_run_cycles", run_cycles, exp_run);
    chk("basic_idle", 32'(current_state), 0);

    // ---- back-pressure + zero layers ----
    tiles_a = 4; tiles_b = 0; tiles_c = 0; start = 1'b1; tile_valid = 1'b0;
    step();
    start = 1'b0;
    acc = 0;
    for (int i = 0; i < 14; i++) begin
      tile_valid = (i < 7) && (i % 2 == 0);
      #1;
      if (tile_valid && tile_ready) acc++;
      chk($sformatf("bp_st%0d", i),  32'(current_state), 32'(p_st[i]));
      chk($sformatf("bp_rdy%0d", i), 32'(tile_ready),    32'(p_rdy[i]));
      chk($sformatf("bp_cnt%0d", i), 32'(tile_cnt),      32'(p_cnt[i]));
      chk($sformatf("bp_done%0d", i), 32'(done), (i == 12) ? 32'd1 : 32'd0);
      step();
    end
    chk("bp_beats", 32'(acc), 4);

    // ---- abort mid-B ----
    tiles_a = 2; tiles_b = 3; tiles_c = 2; tile_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("abort_pre_st",  32'(current_state), 2);
    chk("abort_pre_cnt", 32'(tile_cnt), 1);
    state_rst = 1'b1;
    #1;
    chk("abort_ready", 32'(tile_ready), 0);
    chk("abort_lf",    32'(layer_first), 0);
    step();
    state_rst = 1'b0;
    chk("abort_st",   32'(current_state), 0);
    chk("abort_cnt",  32'(tile_cnt), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_run",  run_cycles, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort_idle_st%0d", i),   32'(current_state), 0);
      chk($sformatf("abort_idle_done%0d", i), 32'(done), 0);
    end

    // ---- start ignored during A (A keeps its 5-beat count) ----
    tiles_a = 5; tiles_b = 1; tiles_c = 1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) begin
        start = 1'b1;
        tiles_a = 1;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("ign_st%0d", i), 32'(current_state), (i < 8) ? 32'd1 : 32'd2);
      step();
    end
    start = 1'b0;
    state_rst = 1'b1;
    step();
    state_rst = 1'b0;
    chk("ign_abort_st", 32'(current_state), 0);
    start = 1'b1; state_rst = 1'b1; tiles_a = 2;
    step();
    start = 1'b0; state_rst = 1'b0;
    chk("ign_rststart_st",   32'(current_state), 0);
    chk("ign_rststart_busy", 32'(busy), 0);
    step();
    chk("ign_rststart_st2", 32'(current_state), 0);

    // ---- async reset mid-C ----
    tiles_a = 1; tiles_b = 1; tiles_c = 5; tile_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("arst_pre_st",  32'(current_state), 3);
    chk("arst_pre_cnt", 32'(tile_cnt), 2);
    #1 rstn = 1'b0;
    #1;
    chk("arst_st",    32'(current_state), 0);
    chk("arst_ready", 32'(tile_ready), 0);
    chk("arst_cnt",   32'(tile_cnt), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_lf",    32'(layer_first), 0);
    chk("arst_run",   run_cycles, 0);
    #4 rstn = 1'b1;
    step();
    chk("arst_idle_st",  32'(current_state), 0);
    chk("arst_idle_rdy", 32'(tile_ready), 0);
    step();
    chk("arst_idle_st2", 32'(current_state), 0);
    tiles_a = 1; tiles_b = 0; tiles_c = 0; start = 1'b1;
    step();
    start = 1'b0;
    chk("arst_restart_st",  32'(current_state), 1);
    chk("arst_restart_rdy", 32'(tile_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
